// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues ROM requests and presents fetched words to ID.
// Latency: one instruction per cycle when the ROM is never busy; the word appears on the edge where the handshake completes.
// Backpressure: rom_busy holds the request; stall parks a completed word in a one-entry hold buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] rom_inst,
    input  logic        rom_busy,
    output logic [31:0] rom_addr,
    output logic        rom_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] STEP = 32'(PC_STEP);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] tgt, tgt_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [31:0] if_pc_nxt;
    logic [31:0] if_inst_nxt;
    logic        if_valid_nxt;
    logic [31:0] fetch_cnt_nxt;
    logic [31:0] redir_tgt;

    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign rom_addr  = pc;
    assign rom_valid = (state == FETCH) || (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            tgt       <= RESET_PC;
            buf_pc    <= '0;
            buf_inst  <= NOP;
            if_pc     <= '0;
            if_inst   <= NOP;
            if_valid  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            tgt       <= tgt_nxt;
            buf_pc    <= buf_pc_nxt;
            buf_inst  <= buf_inst_nxt;
            if_pc     <= if_pc_nxt;
            if_inst   <= if_inst_nxt;
            if_valid  <= if_valid_nxt;
            fetch_cnt <= fetch_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        tgt_nxt       = tgt;
        buf_pc_nxt    = buf_pc;
        buf_inst_nxt  = buf_inst;
        if_pc_nxt     = if_pc;
        if_inst_nxt   = if_inst;
        if_valid_nxt  = if_valid;
        fetch_cnt_nxt = fetch_cnt;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nxt = redir_tgt;
                end else begin
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                if (redirect) begin
                    if_valid_nxt = 1'b0;
                    if (rom_busy) begin
                        // ROM is mid-access: keep the request up and remember where to go.
                        state_nxt = FLUSH;
                        tgt_nxt   = redir_tgt;
                    end else begin
                        pc_nxt = redir_tgt;
                    end
                end else if (!rom_busy) begin
                    if (stall) begin
                        buf_inst_nxt = rom_inst;
                        buf_pc_nxt   = pc;
                        state_nxt    = HOLD;
                    end else begin
                        if_inst_nxt   = rom_inst;
                        if_pc_nxt     = pc;
                        if_valid_nxt  = 1'b1;
                        pc_nxt        = pc + STEP;
                        fetch_cnt_nxt = fetch_cnt + 32'd1;
                    end
                end else if (!stall) begin
                    // ID took the presented word and nothing new arrived: emit a bubble.
                    if_valid_nxt = 1'b0;
                end
            end

            FLUSH: begin
                if (redirect) begin
                    tgt_nxt = redir_tgt;
                end
                if (!rom_busy) begin
                    pc_nxt    = redirect ? redir_tgt : tgt;
                    state_nxt = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt       = redir_tgt;
                    if_valid_nxt = 1'b0;
                    state_nxt    = FETCH;
                end else if (!stall) begin
                    if_inst_nxt   = buf_inst;
                    if_pc_nxt     = buf_pc;
                    if_valid_nxt  = 1'b1;
                    pc_nxt        = buf_pc + STEP;
                    fetch_cnt_nxt = fetch_cnt + 32'd1;
                    state_nxt     = FETCH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized stall/redirect/ROM latency,
// with a program-order reference stream checked by an independent monitor.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] rom_inst;
    logic        rom_busy = 1'b0;
    logic [31:0] rom_addr;
    logic        rom_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [31:0] fetch_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_push = RESET_PC;
    int          lat_mode = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_inst = inst_of(rom_addr);

    inst_fetch #(
        .RESET_PC(RESET_PC),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .rom_inst   (rom_inst),
        .rom_busy   (rom_busy),
        .rom_addr   (rom_addr),
        .rom_valid  (rom_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_valid   (if_valid),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the ID stage must see a program-order stream that restarts at every redirect target.
    task automatic model_restart(input logic [31:0] a);
        exp_q.delete();
        next_push = a & 32'hFFFF_FFFC;
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        if (r) model_restart(rpc);
        refill();
        @(negedge clk);
    endtask

    task automatic do_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        #2 rst_n = 1'b0;
        model_restart(RESET_PC);
        refill();
        #1;
        chk("rst_rom_valid", 32'(rom_valid), 32'd0);
        chk("rst_rom_addr", rom_addr, RESET_PC);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, NOP);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input string name, input logic [31:0] target, input int budget, output int n);
        n = 0;
        while (fetch_cnt != target && n < budget) begin
            cyc(1'b0, 1'b0, 32'd0);
            n++;
        end
        chk(name, fetch_cnt, target);
    endtask

    // ROM model: each new request is busy for cur_lat cycles before the word is returned.
    int   reqcyc = 0;
    int   cur_lat = 0;
    logic prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reqcyc     = 0;
                prev_valid = 1'b0;
                rom_busy   = 1'b0;
            end else begin
                if ((prev_valid && !rom_busy) || !rom_valid) reqcyc = 0;
                if (rom_valid) begin
                    if (reqcyc == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    rom_busy = (reqcyc < cur_lat);
                    reqcyc++;
                end else begin
                    rom_busy = 1'b0;
                end
                prev_valid = rom_valid;
            end
        end
    end

    // Monitor: snapshot before each rising edge, judge what the edge produced.
    logic        pre_rst, pre_stall, pre_red, pre_busy, pre_rv, pre_ifv;
    logic [31:0] pre_addr, pre_cnt, pre_pc, pre_inst, exp_pc;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            pre_rst   = rst_n;
            pre_stall = stall;
            pre_red   = redirect;
            pre_busy  = rom_busy;
            pre_rv    = rom_valid;
            pre_ifv   = if_valid;
            pre_addr  = rom_addr;
            pre_cnt   = fetch_cnt;
            pre_pc    = if_pc;
            pre_inst  = if_inst;
            @(posedge clk);
            #1;
            if (pre_rst && rst_n) begin
                chk("rom_addr_align", 32'(rom_addr[1:0]), 32'd0);
                if (pre_rv && pre_busy) begin
                    chk("req_held_valid", 32'(rom_valid), 32'd1);
                    chk("req_held_addr", rom_addr, pre_addr);
                end
                if (fetch_cnt != pre_cnt) begin
                    chk("cnt_step", fetch_cnt, pre_cnt + 32'd1);
                    chk("deliver_valid", 32'(if_valid), 32'd1);
                    chk("deliver_when_stall_or_redirect", 32'({pre_stall, pre_red}), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL deliver_unexpected: got pc %h, required no delivery", if_pc);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        chk("deliver_pc", if_pc, exp_pc);
                        chk("deliver_inst", if_inst, inst_of(exp_pc));
                    end
                end else if (pre_red) begin
                    chk("redirect_kills_valid", 32'(if_valid), 32'd0);
                end else if (pre_stall) begin
                    chk("stall_pc_frozen", if_pc, pre_pc);
                    chk("stall_inst_frozen", if_inst, pre_inst);
                    chk("stall_valid_frozen", 32'(if_valid), 32'(pre_ifv));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          r;
        logic        s;
        logic        rd;
        logic [31:0] a;

        @(negedge clk);

        // Zero-latency ROM: one instruction per cycle.
        lat_mode = 0;
        do_reset();
        cyc(1'b0, 1'b0, 32'd0);
        chk("t1_first_valid", 32'(rom_valid), 32'd1);
        chk("t1_first_addr", rom_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'd0);
            chk("t1_addr", rom_addr, 32'(4 * (i + 1)));
            chk("t1_if_pc", if_pc, 32'(4 * i));
            chk("t1_if_valid", 32'(if_valid), 32'd1);
        end
        chk("t1_cnt", fetch_cnt, 32'd4);

        // Three busy cycles per request: four fetches in sixteen cycles.
        lat_mode = 3;
        do_reset();
        cyc(1'b0, 1'b0, 32'd0);
        n = 0;
        while (fetch_cnt != 32'd4 && n < 40) begin
            cyc(1'b0, 1'b0, 32'd0);
            n++;
        end
        chk("t2_cycles", 32'(n), 32'd16);
        chk("t2_last_pc", if_pc, 32'd12);

        // Stall while the word at pc=8 completes.
        lat_mode = 0;
        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        chk("t3_addr_before", rom_addr, 32'd8);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 32'd0);
            chk("t3_hold_pc", if_pc, 32'd4);
            chk("t3_hold_rom_valid", 32'(rom_valid), 32'd0);
        end
        cyc(1'b0, 1'b0, 32'd0);
        chk("t3_release_pc", if_pc, 32'd8);
        chk("t3_release_valid", 32'(if_valid), 32'd1);
        cyc(1'b0, 1'b0, 32'd0);
        chk("t3_next_pc", if_pc, 32'd12);
        chk("t3_cnt", fetch_cnt, 32'd4);

        // Redirect while the ROM is busy on pc=0x10.
        lat_mode = 3;
        do_reset();
        n = 0;
        while (rom_addr != 32'h10 && n < 60) begin
            cyc(1'b0, 1'b0, 32'd0);
            n++;
        end
        chk("t4_reach_0x10", rom_addr, 32'h10);
        cyc(1'b0, 1'b1, 32'h100);
        chk("t4_flush_addr", rom_addr, 32'h10);
        chk("t4_flush_valid", 32'(rom_valid), 32'd1);
        chk("t4_if_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 32'd0);
            chk("t4_flush_addr_hold", rom_addr, 32'h10);
            chk("t4_flush_valid_hold", 32'(rom_valid), 32'd1);
        end
        cyc(1'b0, 1'b0, 32'd0);
        chk("t4_new_addr", rom_addr, 32'h100);
        chk("t4_discard", 32'(if_valid), 32'd0);
        chk("t4_cnt_kept", fetch_cnt, 32'd4);
        wait_cnt("t4_wait", 32'd5, 20, n);
        chk("t4_if_pc", if_pc, 32'h100);

        // Redirect on the completion edge while stalled.
        lat_mode = 0;
        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h203);
        chk("t5_addr", rom_addr, 32'h200);
        chk("t5_rom_valid", 32'(rom_valid), 32'd1);
        chk("t5_if_valid", 32'(if_valid), 32'd0);
        chk("t5_cnt", fetch_cnt, 32'd2);
        cyc(1'b0, 1'b0, 32'd0);
        chk("t5_if_pc", if_pc, 32'h200);
        chk("t5_cnt_next", fetch_cnt, 32'd3);

        // Reset asserted while flushing.
        lat_mode = 3;
        do_reset();
        cyc(1'b0, 1'b0, 32'd0);
        wait_cnt("t6_first", 32'd1, 20, n);
        cyc(1'b0, 1'b1, 32'h40);
        chk("t6_in_flush_valid", 32'(rom_valid), 32'd1);
        chk("t6_in_flush_addr", rom_addr, 32'd4);
        do_reset();
        wait_cnt("t6_restart", 32'd1, 20, n);
        chk("t6_restart_pc", if_pc, RESET_PC);

        // Randomized traffic, including targets near the top of the address space.
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset();
            end else begin
                s  = ($urandom_range(0, 99) < 30);
                rd = ($urandom_range(0, 99) < 6);
                if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                else a = $urandom;
                cyc(s, rd, a);
            end
        end
        repeat (2) cyc(1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
